// File: rtl/panxi_ctrl_pkg.sv
// Shared definitions for the PANXI pipeline control unit: stall encodings,
// controller state encodings and a small helper to merge stall requests.
package panxi_ctrl_pkg;

    localparam int HOLD_WIDTH = 2;

    // Stall encodings; a larger value freezes more of the front end.
    localparam logic [HOLD_WIDTH-1:0] HOLD_NONE = 2'd0;  // nothing frozen
    localparam logic [HOLD_WIDTH-1:0] HOLD_PC   = 2'd1;  // PC frozen
    localparam logic [HOLD_WIDTH-1:0] HOLD_IF   = 2'd2;  // PC + IF frozen
    localparam logic [HOLD_WIDTH-1:0] HOLD_ID   = 2'd3;  // PC + IF + ID frozen

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_INT_PEND = 2'd2,
        ST_HALT     = 2'd3
    } state_e;

    // Overlapping stall requests resolve to the one that freezes the most stages.
    function automatic logic [HOLD_WIDTH-1:0] hold_max(
        input logic [HOLD_WIDTH-1:0] a,
        input logic [HOLD_WIDTH-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/panxi_ctrl.sv
// PANXI RV32 pipeline control unit. Single source of PC redirects and
// front-end stalls: arbitrates EX jumps, CLINT interrupts and JTAG halt,
// and sequences the flush bubbles that follow every redirect.
module panxi_ctrl
    import panxi_ctrl_pkg::*;
#(
    parameter int DW           = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_jmp_en_i,
    input  logic [DW-1:0]         ex_jmp_addr_i,
    input  logic                  ex_hold_i,
    input  logic                  bus_hold_i,
    input  logic                  int_req_i,
    input  logic [DW-1:0]         int_addr_i,
    output logic                  int_ack_o,
    input  logic                  jtag_halt_i,
    output logic                  jtag_halted_o,
    output logic                  jmp_en_o,
    output logic [DW-1:0]         jmp_addr_o,
    output logic [HOLD_WIDTH-1:0] hold_flag_o,
    output logic                  flush_o
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

    state_e            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DW-1:0]     int_addr_q_reg;
    logic              flush_reg;
    logic              halted_reg;

    logic              holds_clear;
    logic [HOLD_WIDTH-1:0] base_hold;

    assign holds_clear = !ex_hold_i && !bus_hold_i;
    // A busy EX unit freezes through ID; a slow instruction bus only freezes PC.
    assign base_hold   = ex_hold_i  ? HOLD_ID :
                         bus_hold_i ? HOLD_PC : HOLD_NONE;

    // Controller FSM: state, flush counter, latched interrupt target and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_RUN;
            cnt_reg        <= '0;
            int_addr_q_reg <= '0;
            flush_reg      <= 1'b0;
            halted_reg     <= 1'b0;
        end else if (jtag_halt_i) begin
            // Halt beats everything; a same-cycle jump is still driven out combinationally.
            state_reg  <= ST_HALT;
            cnt_reg    <= '0;
            flush_reg  <= 1'b0;
            halted_reg <= 1'b1;
        end else begin
            halted_reg <= 1'b0;
            case (state_reg)
                ST_RUN: begin
                    if (ex_jmp_en_i || (int_req_i && holds_clear)) begin
                        state_reg <= ST_FLUSH;
                        cnt_reg   <= CNT_RELOAD;
                        flush_reg <= 1'b1;
                    end else if (int_req_i) begin
                        // Interrupt blocked by a stall: remember where to go once it clears.
                        state_reg      <= ST_INT_PEND;
                        int_addr_q_reg <= int_addr_i;
                        flush_reg      <= 1'b0;
                    end else begin
                        flush_reg <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (ex_jmp_en_i) begin
                        cnt_reg   <= CNT_RELOAD;
                        flush_reg <= 1'b1;
                    end else if (cnt_reg == '0) begin
                        state_reg <= ST_RUN;
                        flush_reg <= 1'b0;
                    end else begin
                        cnt_reg   <= cnt_reg - 1'b1;
                        flush_reg <= 1'b1;
                    end
                end
                ST_INT_PEND: begin
                    // A jump overrides the pending interrupt; it is re-arbitrated from RUN later.
                    if (ex_jmp_en_i || holds_clear) begin
                        state_reg <= ST_FLUSH;
                        cnt_reg   <= CNT_RELOAD;
                        flush_reg <= 1'b1;
                    end else begin
                        flush_reg <= 1'b0;
                    end
                end
                default: begin
                    // ST_HALT with the halt request released.
                    state_reg <= ST_RUN;
                    flush_reg <= 1'b0;
                end
            endcase
        end
    end

    // Zero-latency redirect, interrupt ack and stall outputs from state and live inputs.
    always_comb begin
        jmp_en_o    = 1'b0;
        jmp_addr_o  = '0;
        int_ack_o   = 1'b0;
        hold_flag_o = HOLD_NONE;
        if (!rst) begin
            case (state_reg)
                ST_RUN: begin
                    hold_flag_o = base_hold;
                    if (ex_jmp_en_i) begin
                        jmp_en_o   = 1'b1;
                        jmp_addr_o = ex_jmp_addr_i;
                    end else if (int_req_i && holds_clear && !jtag_halt_i) begin
                        jmp_en_o   = 1'b1;
                        jmp_addr_o = int_addr_i;
                        int_ack_o  = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    hold_flag_o = base_hold;
                    if (ex_jmp_en_i) begin
                        jmp_en_o   = 1'b1;
                        jmp_addr_o = ex_jmp_addr_i;
                    end
                end
                ST_INT_PEND: begin
                    hold_flag_o = hold_max(HOLD_IF, base_hold);
                    if (ex_jmp_en_i) begin
                        jmp_en_o   = 1'b1;
                        jmp_addr_o = ex_jmp_addr_i;
                    end else if (holds_clear && !jtag_halt_i) begin
                        jmp_en_o   = 1'b1;
                        jmp_addr_o = int_addr_q_reg;
                        int_ack_o  = 1'b1;
                    end
                end
                default: begin
                    hold_flag_o = HOLD_ID;
                end
            endcase
        end
    end

    assign flush_o       = flush_reg;
    assign jtag_halted_o = halted_reg;

endmodule

// File: tb/tb_panxi_ctrl.sv
// Directed testbench for panxi_ctrl: inputs change on the falling edge,
// outputs are checked 1 ns later, well away from the rising edge.
module tb_panxi_ctrl;
    import panxi_ctrl_pkg::*;

    localparam int DW = 32;

    logic                  clk;
    logic                  rst;
    logic                  ex_jmp_en_i;
    logic [DW-1:0]         ex_jmp_addr_i;
    logic                  ex_hold_i;
    logic                  bus_hold_i;
    logic                  int_req_i;
    logic [DW-1:0]         int_addr_i;
    logic                  int_ack_o;
    logic                  jtag_halt_i;
    logic                  jtag_halted_o;
    logic                  jmp_en_o;
    logic [DW-1:0]         jmp_addr_o;
    logic [HOLD_WIDTH-1:0] hold_flag_o;
    logic                  flush_o;

    int n_assert = 0;
    int n_fail   = 0;

    panxi_ctrl #(.DW(DW), .FLUSH_CYCLES(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_jmp_en_i   (ex_jmp_en_i),
        .ex_jmp_addr_i (ex_jmp_addr_i),
        .ex_hold_i     (ex_hold_i),
        .bus_hold_i    (bus_hold_i),
        .int_req_i     (int_req_i),
        .int_addr_i    (int_addr_i),
        .int_ack_o     (int_ack_o),
        .jtag_halt_i   (jtag_halt_i),
        .jtag_halted_o (jtag_halted_o),
        .jmp_en_o      (jmp_en_o),
        .jmp_addr_o    (jmp_addr_o),
        .hold_flag_o   (hold_flag_o),
        .flush_o       (flush_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Move to the next falling edge, then let combinational outputs settle.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    // Check the full output set against expected values.
    task automatic chk_all(input string tag, input logic jen, input logic [DW-1:0] jaddr,
                           input logic ack, input logic [HOLD_WIDTH-1:0] hold,
                           input logic fl, input logic hl);
        chk({tag, ".jmp_en"},  64'(jmp_en_o),      64'(jen));
        chk({tag, ".jmp_addr"},64'(jmp_addr_o),    64'(jaddr));
        chk({tag, ".int_ack"}, 64'(int_ack_o),     64'(ack));
        chk({tag, ".hold"},    64'(hold_flag_o),   64'(hold));
        chk({tag, ".flush"},   64'(flush_o),       64'(fl));
        chk({tag, ".halted"},  64'(jtag_halted_o), 64'(hl));
        $display("step %s: jmp_en=%0b addr=0x%0h ack=%0b hold=%0d flush=%0b halted=%0b",
                 tag, jmp_en_o, jmp_addr_o, int_ack_o, hold_flag_o, flush_o, jtag_halted_o);
    endtask

    initial begin
        rst = 1'b1; ex_jmp_en_i = 1'b0; ex_jmp_addr_i = '0; ex_hold_i = 1'b0;
        bus_hold_i = 1'b0; int_req_i = 1'b0; int_addr_i = '0; jtag_halt_i = 1'b0;

        // 1. Reset for two cycles, then idle
        next_cycle(); settle(); chk_all("rst0", 0, 0, 0, HOLD_NONE, 0, 0);
        next_cycle(); settle(); chk_all("rst1", 0, 0, 0, HOLD_NONE, 0, 0);
        next_cycle(); rst = 1'b0; settle(); chk_all("idle", 0, 0, 0, HOLD_NONE, 0, 0);

        // Bus wait alone freezes only the PC
        next_cycle(); bus_hold_i = 1'b1; settle(); chk_all("bus_hold", 0, 0, 0, HOLD_PC, 0, 0);
        next_cycle(); bus_hold_i = 1'b0;

        // 2. EX jump: same-cycle redirect, flush for exactly two cycles
        ex_jmp_en_i = 1'b1; ex_jmp_addr_i = 32'h100; settle();
        chk_all("jmp", 1, 32'h100, 0, HOLD_NONE, 0, 0);
        next_cycle(); ex_jmp_en_i = 1'b0; ex_jmp_addr_i = '0; settle();
        chk_all("jmp_fl1", 0, 0, 0, HOLD_NONE, 1, 0);
        next_cycle(); settle(); chk_all("jmp_fl2", 0, 0, 0, HOLD_NONE, 1, 0);
        next_cycle(); settle(); chk_all("jmp_done", 0, 0, 0, HOLD_NONE, 0, 0);

        // 3. Interrupt blocked by a 3-cycle EX stall, then taken from the latched address
        next_cycle(); int_req_i = 1'b1; int_addr_i = 32'h80; ex_hold_i = 1'b1; settle();
        chk_all("int_blk1", 0, 0, 0, HOLD_ID, 0, 0);
        next_cycle(); settle(); chk_all("int_blk2", 0, 0, 0, HOLD_ID, 0, 0);
        next_cycle(); settle(); chk_all("int_blk3", 0, 0, 0, HOLD_ID, 0, 0);
        next_cycle(); ex_hold_i = 1'b0; int_addr_i = 32'h444; settle();
        chk_all("int_take", 1, 32'h80, 1, HOLD_IF, 0, 0);
        next_cycle(); int_req_i = 1'b0; int_addr_i = '0; settle();
        chk_all("int_fl1", 0, 0, 0, HOLD_NONE, 1, 0);
        next_cycle(); settle(); chk_all("int_fl2", 0, 0, 0, HOLD_NONE, 1, 0);
        next_cycle(); settle(); chk_all("int_done", 0, 0, 0, HOLD_NONE, 0, 0);

        // 4. Jump and interrupt in the same cycle: jump first, interrupt after the flush
        next_cycle(); ex_jmp_en_i = 1'b1; ex_jmp_addr_i = 32'h200;
        int_req_i = 1'b1; int_addr_i = 32'h80; settle();
        chk_all("both_jmp", 1, 32'h200, 0, HOLD_NONE, 0, 0);
        next_cycle(); ex_jmp_en_i = 1'b0; ex_jmp_addr_i = '0; settle();
        chk_all("both_fl1", 0, 0, 0, HOLD_NONE, 1, 0);
        next_cycle(); settle(); chk_all("both_fl2", 0, 0, 0, HOLD_NONE, 1, 0);
        next_cycle(); settle(); chk_all("both_int", 1, 32'h80, 1, HOLD_NONE, 0, 0);
        next_cycle(); int_req_i = 1'b0; int_addr_i = '0; settle();
        chk_all("both_fl3", 0, 0, 0, HOLD_NONE, 1, 0);
        next_cycle(); settle(); chk_all("both_fl4", 0, 0, 0, HOLD_NONE, 1, 0);
        next_cycle(); settle(); chk_all("both_done", 0, 0, 0, HOLD_NONE, 0, 0);

        // 5. Halt requested during FLUSH, jump ignored while halted, then release
        next_cycle(); ex_jmp_en_i = 1'b1; ex_jmp_addr_i = 32'h300; settle();
        chk_all("h_jmp", 1, 32'h300, 0, HOLD_NONE, 0, 0);
        next_cycle(); ex_jmp_en_i = 1'b0; ex_jmp_addr_i = '0; jtag_halt_i = 1'b1; settle();
        chk_all("h_req", 0, 0, 0, HOLD_NONE, 1, 0);
        next_cycle(); ex_jmp_en_i = 1'b1; ex_jmp_addr_i = 32'h340; settle();
        chk_all("h_halted", 0, 0, 0, HOLD_ID, 0, 1);
        next_cycle(); ex_jmp_en_i = 1'b0; ex_jmp_addr_i = '0; jtag_halt_i = 1'b0; settle();
        chk_all("h_rel", 0, 0, 0, HOLD_ID, 0, 1);
        next_cycle(); settle(); chk_all("h_run", 0, 0, 0, HOLD_NONE, 0, 0);

        // 6. Reset while an interrupt is pending: no ack, back to idle
        next_cycle(); int_req_i = 1'b1; int_addr_i = 32'h500; bus_hold_i = 1'b1; settle();
        chk_all("r_blk", 0, 0, 0, HOLD_PC, 0, 0);
        next_cycle(); settle(); chk_all("r_pend", 0, 0, 0, HOLD_IF, 0, 0);
        next_cycle(); rst = 1'b1; bus_hold_i = 1'b0; int_req_i = 1'b0; int_addr_i = '0; settle();
        chk_all("r_rst", 0, 0, 0, HOLD_NONE, 0, 0);
        next_cycle(); rst = 1'b0; settle(); chk_all("r_after", 0, 0, 0, HOLD_NONE, 0, 0);
        next_cycle(); settle(); chk_all("r_idle", 0, 0, 0, HOLD_NONE, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
